multicycle_ctrl: RTL and testbench

Control sequencer for the multicycle MIPS-subset CPU. The datapath shares one memory port for instruction fetch and data access and holds IR, A/B and ALUOut registers. This block steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every write strobe and mux select on that datapath. It waits on a memory-ready handshake, traps on illegal opcodes and counts retired instructions.

---
 rtl/multicycle_ctrl_pkg.sv | 61 ++++++
 rtl/multicycle_ctrl_decode.sv | 35 +++
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control sequencer:
// states, opcodes, instruction classes and datapath select codes.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE,
    C_ADDI,
    C_XORI,
    C_LW,
    C_SW,
    C_BEQ,
    C_BNE,
    C_J,
    C_JAL,
    C_JR,
    C_ILLEGAL
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;

  localparam logic [1:0] PC_INC   = 2'd0;
  localparam logic [1:0] PC_BR    = 2'd1;
  localparam logic [1:0] PC_JMP   = 2'd2;
  localparam logic [1:0] PC_REG   = 2'd3;

  localparam logic [1:0] DST_RT   = 2'd0;
  localparam logic [1:0] DST_RD   = 2'd1;
  localparam logic [1:0] DST_R31  = 2'd2;

  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MDR   = 2'd1;
  localparam logic [1:0] WB_PC    = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode/funct classifier for the control sequencer.
// Any opcode or R-type funct not listed maps to C_ILLEGAL.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls
);

  always_comb begin
    cls = C_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD,
          FN_SUB,
          FN_SLT:  cls = C_RTYPE;
          FN_JR:   cls = C_JR;
          default: cls = C_ILLEGAL;
        endcase
      end
      OP_ADDI: cls = C_ADDI;
      OP_XORI: cls = C_XORI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_BNE:  cls = C_BNE;
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping,
// datapath strobes, sticky trap flag and retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             iord,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             alu_src,
  output logic [2:0]       alu_ctrl,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q;
  state_t           state_d;
  cls_t             cls;
  logic             trap_q;
  logic [CNT_W-1:0] retired_q;
  logic             mem_wr_r;
  logic             ir_wr_r;
  logic             pc_wr_r;
  logic             reg_wr_r;
  logic             done_r;

  multicycle_ctrl_decode u_decode (
    .op    (op),
    .funct (funct),
    .cls   (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      trap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP)
        trap_q <= 1'b1;
      if (done_r)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_rd   = 1'b0;
    mem_wr_r = 1'b0;
    iord     = 1'b0;
    ir_wr_r  = 1'b0;
    pc_wr_r  = 1'b0;
    pc_src   = PC_INC;
    reg_wr_r = 1'b0;
    reg_dst  = DST_RT;
    wb_sel   = WB_ALU;
    alu_src  = 1'b0;
    alu_ctrl = ALU_ADD;
    done_r   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_wr_r = 1'b1;
          pc_wr_r = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (cls == C_ILLEGAL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        done_r  = 1'b1;
        case (cls)
          C_RTYPE: begin
            done_r  = 1'b0;
            state_d = S_WB;
            case (funct)
              FN_SUB:  alu_ctrl = ALU_SUB;
              FN_SLT:  alu_ctrl = ALU_SLT;
              default: alu_ctrl = ALU_ADD;
            endcase
          end
          C_ADDI, C_LW, C_SW: begin
            done_r  = 1'b0;
            alu_src = 1'b1;
            state_d = (cls == C_ADDI) ? S_WB : S_MEM;
          end
          C_XORI: begin
            done_r   = 1'b0;
            alu_src  = 1'b1;
            alu_ctrl = ALU_XOR;
            state_d  = S_WB;
          end
          C_BEQ, C_BNE: begin
            alu_ctrl = ALU_SUB;
            pc_src   = PC_BR;
            pc_wr_r  = (cls == C_BEQ) ? zero : ~zero;
          end
          C_J: begin
            pc_src  = PC_JMP;
            pc_wr_r = 1'b1;
          end
          C_JAL: begin
            pc_src   = PC_JMP;
            pc_wr_r  = 1'b1;
            reg_wr_r = 1'b1;
            reg_dst  = DST_R31;
            wb_sel   = WB_PC;
          end
          C_JR: begin
            pc_src  = PC_REG;
            pc_wr_r = 1'b1;
          end
          default: begin
            done_r  = 1'b0;
            state_d = S_TRAP;
          end
        endcase
      end
      S_MEM: begin
        iord     = 1'b1;
        mem_rd   = (cls == C_LW);
        mem_wr_r = (cls == C_SW);
        if (mem_ready) begin
          state_d = (cls == C_LW) ? S_WB : S_FETCH;
          done_r  = (cls != C_LW);
        end
      end
      S_WB: begin
        reg_wr_r = 1'b1;
        done_r   = 1'b1;
        state_d  = S_FETCH;
        case (cls)
          C_RTYPE: reg_dst = DST_RD;
          C_LW:    wb_sel  = WB_MDR;
          default: reg_dst = DST_RT;
        endcase
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset abandons whatever is in flight, so no write may escape that cycle.
  assign mem_wr     = mem_wr_r & ~reset;
  assign ir_wr      = ir_wr_r  & ~reset;
  assign pc_wr      = pc_wr_r  & ~reset;
  assign reg_wr     = reg_wr_r & ~reset;
  assign instr_done = done_r   & ~reset;
  assign state      = state_q;
  assign trap       = trap_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors
// go through a scoreboard queue and are compared mid-cycle.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        mem_rd;
  logic        mem_wr;
  logic        iord;
  logic        ir_wr;
  logic        pc_wr;
  logic [1:0]  pc_src;
  logic        reg_wr;
  logic [1:0]  reg_dst;
  logic [1:0]  wb_sel;
  logic        alu_src;
  logic [2:0]  alu_ctrl;
  logic [2:0]  state;
  logic        instr_done;
  logic        trap;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [20:0] v;
  } exp_t;

  exp_t sb[$];

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .iord       (iord),
    .ir_wr      (ir_wr),
    .pc_wr      (pc_wr),
    .pc_src     (pc_src),
    .reg_wr     (reg_wr),
    .reg_dst    (reg_dst),
    .wb_sel     (wb_sel),
    .alu_src    (alu_src),
    .alu_ctrl   (alu_ctrl),
    .state      (state),
    .instr_done (instr_done),
    .trap       (trap),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] mk(
    input logic [2:0] st, input logic rd, input logic wr,
    input logic io, input logic irw, input logic pcw,
    input logic [1:0] pcs, input logic rw, input logic [1:0] rdst,
    input logic [1:0] wbs, input logic as, input logic [2:0] alu,
    input logic dn, input logic tr);
    return {st, rd, wr, io, irw, pcw, pcs, rw, rdst, wbs, as, alu, dn, tr};
  endfunction

  function automatic logic [20:0] obs_vec();
    return {state, mem_rd, mem_wr, iord, ir_wr, pc_wr, pc_src, reg_wr,
            reg_dst, wb_sel, alu_src, alu_ctrl, instr_done, trap};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, compare mid-cycle.
  task automatic cyc(input logic mr, input logic z,
                     input logic [20:0] e, input string tag);
    exp_t x;
    logic [20:0] o;
    mem_ready = mr;
    zero      = z;
    sb.push_back('{tag, e});
    @(negedge clk);
    x = sb.pop_front();
    o = obs_vec();
    checks++;
    assert (o === x.v) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", x.tag, o, x.v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic [5:0] o, input logic [5:0] f);
    op    = o;
    funct = f;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    zero      = 1'b0;
    op        = 6'h00;
    funct     = 6'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);

    // ADD
    set_ins(6'h00, 6'h20);
    cyc(1, 0, mk(0,1,0,0,1,1,0,0,0,0,0,0,0,0), "add_f");
    cyc(1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0), "add_d");
    cyc(1, 0, mk(2,0,0,0,0,0,0,0,0,0,0,0,0,0), "add_e");
    cyc(1, 0, mk(4,0,0,0,0,0,0,1,1,0,0,0,1,0), "add_wb");
    chk("add_retired", retired, 32'd1);

    // LW, 2 FETCH stalls and 3 MEM stalls
    set_ins(6'h23, 6'h00);
    cyc(0, 0, mk(0,1,0,0,0,0,0,0,0,0,0,0,0,0), "lw_f0");
    cyc(0, 0, mk(0,1,0,0,0,0,0,0,0,0,0,0,0,0), "lw_f1");
    cyc(1, 0, mk(0,1,0,0,1,1,0,0,0,0,0,0,0,0), "lw_f2");
    cyc(1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0), "lw_d");
    cyc(1, 0, mk(2,0,0,0,0,0,0,0,0,0,1,0,0,0), "lw_e");
    cyc(0, 0, mk(3,1,0,1,0,0,0,0,0,0,0,0,0,0), "lw_m0");
    cyc(0, 0, mk(3,1,0,1,0,0,0,0,0,0,0,0,0,0), "lw_m1");
    cyc(0, 0, mk(3,1,0,1,0,0,0,0,0,0,0,0,0,0), "lw_m2");
    cyc(1, 0, mk(3,1,0,1,0,0,0,0,0,0,0,0,0,0), "lw_m3");
    cyc(1, 0, mk(4,0,0,0,0,0,0,1,0,1,0,0,1,0), "lw_wb");
    chk("lw_retired", retired, 32'd2);

    // BEQ taken, BNE not taken (zero = 1 for both)
    set_ins(6'h04, 6'h00);
    cyc(1, 1, mk(0,1,0,0,1,1,0,0,0,0,0,0,0,0), "beq_f");
    cyc(1, 1, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0), "beq_d");
    cyc(1, 1, mk(2,0,0,0,0,1,1,0,0,0,0,1,1,0), "beq_e");
    set_ins(6'h05, 6'h00);
    cyc(1, 1, mk(0,1,0,0,1,1,0,0,0,0,0,0,0,0), "bne_f");
    cyc(1, 1, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0), "bne_d");
    cyc(1, 1, mk(2,0,0,0,0,0,1,0,0,0,0,1,1,0), "bne_e");
    chk("br_retired", retired, 32'd4);

    // JAL
    set_ins(6'h03, 6'h00);
    cyc(1, 0, mk(0,1,0,0,1,1,0,0,0,0,0,0,0,0), "jal_f");
    cyc(1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0), "jal_d");
    cyc(1, 0, mk(2,0,0,0,0,1,2,1,2,2,0,0,1,0), "jal_e");

    // XORI
    set_ins(6'h0E, 6'h00);
    cyc(1, 0, mk(0,1,0,0,1,1,0,0,0,0,0,0,0,0), "xori_f");
    cyc(1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0), "xori_d");
    cyc(1, 0, mk(2,0,0,0,0,0,0,0,0,0,1,2,0,0), "xori_e");
    cyc(1, 0, mk(4,0,0,0,0,0,0,1,0,0,0,0,1,0), "xori_wb");

    // SLT
    set_ins(6'h00, 6'h2A);
    cyc(1, 0, mk(0,1,0,0,1,1,0,0,0,0,0,0,0,0), "slt_f");
    cyc(1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0), "slt_d");
    cyc(1, 0, mk(2,0,0,0,0,0,0,0,0,0,0,3,0,0), "slt_e");
    cyc(1, 0, mk(4,0,0,0,0,0,0,1,1,0,0,0,1,0), "slt_wb");

    // JR
    set_ins(6'h00, 6'h08);
    cyc(1, 0, mk(0,1,0,0,1,1,0,0,0,0,0,0,0,0), "jr_f");
    cyc(1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0), "jr_d");
    cyc(1, 0, mk(2,0,0,0,0,1,3,0,0,0,0,0,1,0), "jr_e");
    chk("jr_retired", retired, 32'd8);

    // Illegal opcode: TRAP, sticky, no strobes for 20 cycles
    set_ins(6'h3F, 6'h00);
    cyc(1, 0, mk(0,1,0,0,1,1,0,0,0,0,0,0,0,0), "ill_f");
    cyc(1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0), "ill_d");
    for (int i = 0; i < 20; i++)
      cyc(1, i[0], mk(5,0,0,0,0,0,0,0,0,0,0,0,0,1), "ill_trap");
    chk("ill_retired", retired, 32'd8);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("trap_rst_state", 32'(state), 32'd0);
    chk("trap_rst_trap", 32'(trap), 32'd0);
    chk("trap_rst_retired", retired, 32'd0);

    // Illegal R-type funct
    set_ins(6'h00, 6'h21);
    cyc(1, 0, mk(0,1,0,0,1,1,0,0,0,0,0,0,0,0), "illf_f");
    cyc(1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0), "illf_d");
    cyc(1, 0, mk(5,0,0,0,0,0,0,0,0,0,0,0,0,1), "illf_trap");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // SW with reset landing in MEM while mem_ready = 1
    set_ins(6'h2B, 6'h00);
    cyc(1, 0, mk(0,1,0,0,1,1,0,0,0,0,0,0,0,0), "sw_f");
    cyc(1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0), "sw_d");
    cyc(1, 0, mk(2,0,0,0,0,0,0,0,0,0,1,0,0,0), "sw_e");
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("sw_rst_state", 32'(state), 32'd3);
    chk("sw_rst_memwr", 32'(mem_wr), 32'd0);
    chk("sw_rst_done", 32'(instr_done), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("sw_rst_next", 32'(state), 32'd0);
    chk("sw_rst_retired", retired, 32'd0);

    // Full SW with zero-wait memory
    cyc(1, 0, mk(0,1,0,0,1,1,0,0,0,0,0,0,0,0), "sw2_f");
    cyc(1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0), "sw2_d");
    cyc(1, 0, mk(2,0,0,0,0,0,0,0,0,0,1,0,0,0), "sw2_e");
    cyc(1, 0, mk(3,0,1,1,0,0,0,0,0,0,0,0,1,0), "sw2_m");
    chk("sw2_retired", retired, 32'd1);
    chk("sw2_state", 32'(state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
